// File: rtl/c_unary_scan_ctrl_pkg.sv
// Shared types for the multi-beat unary (thermometer) code classifier.
package c_unary_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  // State carried from one scanned bit to the next, and across beats.
  typedef struct packed {
    logic is_first;     // next bit is bit 0 of the vector
    logic x_prev;       // value of the previously scanned bit
    logic seen_edge;    // one symbol change already observed
    logic all_ones;     // every bit so far is 1
    logic all_zeros_n;  // every bit so far is 0
    logic is_unary;     // prefix still matches 1..10..0
    logic is_unary_n;   // prefix still matches 0..01..1
  } carry_t;

  // Width needed to hold a count in the range 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/c_unary_scan_ctrl_if.sv
// Producer/consumer handshake bundle for the unary scan controller.
interface c_unary_scan_ctrl_if
  import c_unary_scan_ctrl_pkg::*;
#(
  parameter int P_W = 64
);
  localparam int P_CW = cnt_width(P_W);

  logic            i_in_vld;
  logic [P_W-1:0]  i_in_w;
  logic            o_in_rdy;
  logic            o_out_vld;
  logic            i_out_rdy;
  logic            o_out_is_unary;
  logic            o_out_is_unary_n;
  logic [P_CW-1:0] o_out_count;
  logic            o_busy;

  modport slave (
    input  i_in_vld, i_in_w, i_out_rdy,
    output o_in_rdy, o_out_vld, o_out_is_unary, o_out_is_unary_n, o_out_count, o_busy
  );

  modport master (
    output i_in_vld, i_in_w, i_out_rdy,
    input  o_in_rdy, o_out_vld, o_out_is_unary, o_out_is_unary_n, o_out_count, o_busy
  );

endinterface

// File: rtl/c_unary_scan_ctrl_chunk.sv
// Combinational P_K-bit chain of unary-detect cells plus chunk popcount.
module c_unary_chunk
  import c_unary_scan_ctrl_pkg::*;
#(
  parameter int P_K = 8
) (
  input  logic [P_K-1:0]                chunk_w,
  input  carry_t                        c_in,
  output carry_t                        c_out,
  output logic [cnt_width(P_K)-1:0]     pop
);
  localparam int PW = cnt_width(P_K);

  carry_t        c;
  logic [PW-1:0] cnt;
  logic          x;

  // Walk the chunk LSB first; a second symbol change kills both codes.
  always_comb begin
    c   = c_in;
    cnt = '0;
    x   = 1'b0;
    for (int unsigned i = 0; i < P_K; i++) begin
      x = chunk_w[i];
      if (c.is_first) begin
        c.is_unary    = c.is_unary & x;
        c.is_unary_n  = c.is_unary_n & ~x;
        c.all_ones    = x;
        c.all_zeros_n = ~x;
      end else begin
        if (x != c.x_prev) begin
          if (c.seen_edge) begin
            c.is_unary   = 1'b0;
            c.is_unary_n = 1'b0;
          end
          c.seen_edge = 1'b1;
        end
        c.all_ones    = c.all_ones & x;
        c.all_zeros_n = c.all_zeros_n & ~x;
      end
      c.x_prev   = x;
      c.is_first = 1'b0;
      cnt        = cnt + PW'(x);
    end
  end

  assign c_out = c;
  assign pop   = cnt;

endmodule

// File: rtl/c_unary_scan_ctrl.sv
// Scans a wide vector P_K bits per cycle and classifies it as unary code.
module c_unary_scan_ctrl
  import c_unary_scan_ctrl_pkg::*;
#(
  parameter int P_W                   = 64,
  parameter int P_K                   = 8,
  parameter int P_ADMIT_COMPLIMENT_EN = 1
) (
  input logic               clk,
  input logic               arst,
  c_unary_scan_ctrl_if.slave bus
);
  localparam int N  = P_W / P_K;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = cnt_width(P_W);
  localparam int PW = cnt_width(P_K);
  localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);
  localparam carry_t CARRY_INIT = '{
    is_first:    1'b1,
    x_prev:      1'b0,
    seen_edge:   1'b0,
    all_ones:    1'b0,
    all_zeros_n: 1'b0,
    is_unary:    1'b1,
    is_unary_n:  (P_ADMIT_COMPLIMENT_EN != 0)
  };

  state_t          state;
  logic [BW-1:0]   beat;
  logic [P_W-1:0]  vec;
  carry_t          carry;
  carry_t          carry_nxt;
  logic [CW-1:0]   ones;
  logic [CW-1:0]   ones_nxt;
  logic [PW-1:0]   pop;
  logic [P_K-1:0]  chunk;
  logic            killed;

  logic            in_rdy_q;
  logic            out_vld_q;
  logic            is_unary_q;
  logic            is_unary_n_q;
  logic [CW-1:0]   count_q;
  logic            busy_q;

  assign chunk    = vec[beat*P_K +: P_K];
  assign ones_nxt = ones + CW'(pop);
  assign killed   = !carry_nxt.is_unary && !carry_nxt.is_unary_n;

  c_unary_chunk #(
    .P_K (P_K)
  ) u_chunk (
    .chunk_w (chunk),
    .c_in    (carry),
    .c_out   (carry_nxt),
    .pop     (pop)
  );

  // Controller FSM: capture, scan beats with early kill, hold result until taken.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state        <= IDLE;
      beat         <= '0;
      vec          <= '0;
      carry        <= '0;
      ones         <= '0;
      in_rdy_q     <= 1'b1;
      out_vld_q    <= 1'b0;
      is_unary_q   <= 1'b0;
      is_unary_n_q <= 1'b0;
      count_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_in_vld && in_rdy_q) begin
            vec      <= bus.i_in_w;
            beat     <= '0;
            carry    <= CARRY_INIT;
            ones     <= '0;
            in_rdy_q <= 1'b0;
            busy_q   <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          carry <= carry_nxt;
          ones  <= ones_nxt;
          if (beat == LAST_BEAT || killed) begin
            out_vld_q    <= 1'b1;
            is_unary_q   <= carry_nxt.is_unary;
            is_unary_n_q <= carry_nxt.is_unary_n;
            count_q      <= carry_nxt.is_unary   ? ones_nxt :
                            carry_nxt.is_unary_n ? CW'(P_W) - ones_nxt : '0;
            state        <= DONE;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        DONE: begin
          if (bus.i_out_rdy) begin
            out_vld_q    <= 1'b0;
            is_unary_q   <= 1'b0;
            is_unary_n_q <= 1'b0;
            count_q      <= '0;
            in_rdy_q     <= 1'b1;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_in_rdy         = in_rdy_q;
  assign bus.o_out_vld        = out_vld_q;
  assign bus.o_out_is_unary   = is_unary_q;
  assign bus.o_out_is_unary_n = is_unary_n_q;
  assign bus.o_out_count      = count_q;
  assign bus.o_busy           = busy_q;

endmodule

// File: tb/tb_c_unary_scan_ctrl.sv
// Bench for c_unary_scan_ctrl: three instances share one stimulus stream
// (P_K=4 admit=1, P_K=4 admit=0, P_K=16 admit=1) and are scored independently.
module tb_c_unary_scan_ctrl;
  import c_unary_scan_ctrl_pkg::*;

  localparam int W  = 16;
  localparam int CW = cnt_width(W);
  localparam int ND = 3;
  localparam int PK_OF  [ND] = '{4, 4, 16};
  localparam bit ADM_OF [ND] = '{1'b1, 1'b0, 1'b1};

  logic         clk = 1'b0;
  logic         arst;
  logic         in_vld;
  logic [W-1:0] in_w;
  logic         out_rdy;
  bit           b2b = 1'b0;
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;

  c_unary_scan_ctrl_if #(.P_W(W)) bus0 (), bus1 (), bus2 ();

  assign bus0.i_in_vld = in_vld;  assign bus0.i_in_w = in_w;  assign bus0.i_out_rdy = out_rdy;
  assign bus1.i_in_vld = in_vld;  assign bus1.i_in_w = in_w;  assign bus1.i_out_rdy = out_rdy;
  assign bus2.i_in_vld = in_vld;  assign bus2.i_in_w = in_w;  assign bus2.i_out_rdy = out_rdy;

  c_unary_scan_ctrl #(.P_W(W), .P_K(4),  .P_ADMIT_COMPLIMENT_EN(1)) dut0 (.clk(clk), .arst(arst), .bus(bus0.slave));
  c_unary_scan_ctrl #(.P_W(W), .P_K(4),  .P_ADMIT_COMPLIMENT_EN(0)) dut1 (.clk(clk), .arst(arst), .bus(bus1.slave));
  c_unary_scan_ctrl #(.P_W(W), .P_K(16), .P_ADMIT_COMPLIMENT_EN(1)) dut2 (.clk(clk), .arst(arst), .bus(bus2.slave));

  logic          rdy [ND];
  logic          vld [ND];
  logic          iu  [ND];
  logic          iun [ND];
  logic          bsy [ND];
  logic [CW-1:0] cnt [ND];

  assign rdy[0] = bus0.o_in_rdy;  assign vld[0] = bus0.o_out_vld;  assign iu[0] = bus0.o_out_is_unary;
  assign iun[0] = bus0.o_out_is_unary_n;  assign cnt[0] = bus0.o_out_count;  assign bsy[0] = bus0.o_busy;
  assign rdy[1] = bus1.o_in_rdy;  assign vld[1] = bus1.o_out_vld;  assign iu[1] = bus1.o_out_is_unary;
  assign iun[1] = bus1.o_out_is_unary_n;  assign cnt[1] = bus1.o_out_count;  assign bsy[1] = bus1.o_busy;
  assign rdy[2] = bus2.o_in_rdy;  assign vld[2] = bus2.o_out_vld;  assign iu[2] = bus2.o_out_is_unary;
  assign iun[2] = bus2.o_out_is_unary_n;  assign cnt[2] = bus2.o_out_count;  assign bsy[2] = bus2.o_busy;

  // Free-running clock.
  always #5 clk = ~clk;

  // Edge counter used for latency and spacing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference classifier: leading run length, then look for a return to the
  // leading symbol; k is the number of beats the scan occupies.
  function automatic void model(input logic [W-1:0] v, input int pk, input bit adm,
                                output bit u, output bit un, output int c, output int k);
    bit lead;
    int run;
    int j;
    lead = v[0];
    run  = 0;
    while (run < W && v[run] == lead) run++;
    j = run;
    while (j < W && v[j] != lead) j++;
    u  = lead && (j == W);
    un = adm && !lead && (j == W);
    c  = (u || un) ? run : 0;
    if (!adm && !lead) k = 1;
    else if (j < W)    k = j / pk + 1;
    else               k = W / pk;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W:0]   m;
    logic [W-1:0] v;
    int           r;
    r    = $urandom_range(0, W);
    m    = '0;
    m[r] = 1'b1;
    m    = m - 1'b1;
    v    = m[W-1:0];
    case ($urandom_range(0, 5))
      0: ;
      1: v = ~v;
      2: begin r = $urandom_range(0, W - 1); v[r] = ~v[r]; end
      3: v = ($urandom_range(0, 1) != 0) ? '1 : '0;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // Scoreboard state per instance.
  logic [W-1:0] vq [ND][64];
  int           tq [ND][64];
  int           wr [ND];
  int           rd [ND];
  bit           seen [ND];
  int           last_t [ND];
  int           last_k [ND];
  bit           last_ok [ND];

  initial begin
    for (int d = 0; d < ND; d++) begin
      wr[d] = 0; rd[d] = 0; seen[d] = 0; last_t[d] = 0; last_k[d] = 0; last_ok[d] = 0;
    end
  end

  // Monitor: log accepted vectors, check first-valid latency, results in order
  // and back-to-back acceptance spacing.
  always @(negedge clk) begin
    bit mu, mun;
    int mc, mk;
    for (int d = 0; d < ND; d++) begin
      if (arst) begin
        rd[d] = wr[d]; seen[d] = 0; last_ok[d] = 0;
      end else begin
        if (in_vld && rdy[d]) begin
          vq[d][wr[d] % 64] = in_w;
          tq[d][wr[d] % 64] = cyc + 1;
          wr[d]++;
          model(in_w, PK_OF[d], ADM_OF[d], mu, mun, mc, mk);
          if (b2b && last_ok[d])
            check($sformatf("gap_d%0d", d), cyc + 1 - last_t[d], last_k[d] + 2);
          last_t[d] = cyc + 1; last_k[d] = mk; last_ok[d] = b2b;
        end
        if (!vld[d]) begin
          seen[d] = 0;
        end else if (rd[d] == wr[d]) begin
          if (!seen[d]) check($sformatf("spurious_vld_d%0d", d), 1, 0);
          seen[d] = 1;
        end else begin
          model(vq[d][rd[d] % 64], PK_OF[d], ADM_OF[d], mu, mun, mc, mk);
          if (!seen[d]) check($sformatf("lat_d%0d", d), cyc, tq[d][rd[d] % 64] + mk);
          seen[d] = 1;
          if (out_rdy) begin
            check($sformatf("is_unary_d%0d_%h", d, vq[d][rd[d] % 64]), int'(iu[d]), int'(mu));
            check($sformatf("is_unary_n_d%0d_%h", d, vq[d][rd[d] % 64]), int'(iun[d]), int'(mun));
            check($sformatf("count_d%0d_%h", d, vq[d][rd[d] % 64]), int'(cnt[d]), mc);
            rd[d]++;
            seen[d] = 0;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!(rdy[0] && rdy[1] && rdy[2]) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("idle_reached", int'(rdy[0] && rdy[1] && rdy[2]), 1);
  endtask

  task automatic send(input logic [W-1:0] v);
    wait_idle();
    in_w   = v;
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    arst = 1'b1; in_vld = 1'b0; in_w = '0; out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst_rdy_d%0d", d), int'(rdy[d]), 1);
      check($sformatf("rst_vld_d%0d", d), int'(vld[d]), 0);
      check($sformatf("rst_busy_d%0d", d), int'(bsy[d]), 0);
      check($sformatf("rst_u_d%0d", d), int'(iu[d]), 0);
      check($sformatf("rst_un_d%0d", d), int'(iun[d]), 0);
      check($sformatf("rst_cnt_d%0d", d), int'(cnt[d]), 0);
    end
    arst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, one at a time.
    send(16'h00FF); send(16'hFFFF); send(16'h0000); send(16'hFFF0);
    send(16'h0101); send(16'h0001); send(16'h8000); send(16'h7FFF);
    wait_idle();

    // Backpressure: result must hold and new input must be refused.
    out_rdy = 1'b0;
    send(16'h00FF);
    n = 0;
    while (!vld[0] && n < 20) begin @(posedge clk); #1; n++; end
    check("bp_vld", int'(vld[0]), 1);
    in_w = 16'h0F0F; in_vld = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_hold_vld", int'(vld[0]), 1);
      check("bp_hold_u", int'(iu[0]), 1);
      check("bp_hold_cnt", int'(cnt[0]), 8);
      check("bp_hold_rdy", int'(rdy[0]), 0);
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_vld", int'(vld[0]), 0);
    check("bp_rel_rdy", int'(rdy[0]), 1);
    check("bp_rel_busy", int'(bsy[0]), 0);

    // Reset during beat 1: everything returns to idle at once, nothing emitted.
    send(16'h00FF);
    @(posedge clk); #1;
    arst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("mid_rst_busy_d%0d", d), int'(bsy[d]), 0);
      check($sformatf("mid_rst_rdy_d%0d", d), int'(rdy[d]), 1);
      check($sformatf("mid_rst_vld_d%0d", d), int'(vld[d]), 0);
    end
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_hold_vld", int'(vld[0] | vld[1] | vld[2]), 0);
    arst = 1'b0;
    send(16'h0007);
    wait_idle();

    // Back-to-back with valid and ready held high.
    b2b = 1'b1; in_vld = 1'b1; out_rdy = 1'b1;
    repeat (60) begin
      in_w = rand_vec();
      @(posedge clk); #1;
    end
    b2b = 1'b0; in_vld = 1'b0;
    wait_idle();

    // Random traffic with random backpressure.
    repeat (800) begin
      in_vld  = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      in_w    = rand_vec();
      @(posedge clk); #1;
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    wait_idle();
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) check($sformatf("drain_d%0d", d), rd[d], wr[d]);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
